// File: rtl/gem_rx_pkg.sv
// Shared definitions for the GEM RX FIFO writer: status field layout and
// the writer FSM state bundle.
package gem_rx_pkg;

  localparam int STATUS_W         = 45;
  localparam int STATUS_LEN_LSB   = 0;
  localparam int STATUS_ERR_BIT   = 14;
  localparam int STATUS_OVF_BIT   = 15;
  localparam int STATUS_TRUNC_BIT = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PACK    = 2'd1,
    DISCARD = 2'd2,
    FLUSH   = 2'd3
  } rx_state_e;

  // Control state held as one struct so checkers can bind to a single signal.
  typedef struct packed {
    rx_state_e state;
    logic      flush_pend;
    logic      sop_done;
  } rx_ctl_t;

endpackage

// File: rtl/gem_rx_byte_packer.sv
// Little-endian byte-to-word packer. Presents the word being built (including
// the byte offered this cycle) so the caller can register it on completion.
module gem_rx_byte_packer (
  input  logic        rx_clock,
  input  logic        rx_reset,
  input  logic [7:0]  byte_data,
  input  logic        byte_en,
  input  logic        close,
  output logic [31:0] word,
  output logic        word_full
);

  logic [31:0] data_q;
  logic [1:0]  idx_q;

  always_comb begin
    word = data_q;
    if (byte_en) word[{idx_q, 3'b000} +: 8] = byte_data;
    word_full = byte_en & (idx_q == 2'd3);
  end

  // Unused lanes stay zero because the buffer is cleared whenever a word leaves.
  always_ff @(posedge rx_clock or posedge rx_reset) begin
    if (rx_reset) begin
      data_q <= '0;
      idx_q  <= '0;
    end else if (close || word_full) begin
      data_q <= '0;
      idx_q  <= '0;
    end else if (byte_en) begin
      data_q <= word;
      idx_q  <= idx_q + 2'd1;
    end
  end

endmodule

// File: rtl/gem_rx_writer.sv
// GEM RX FIFO writer: packs an 8-bit frame stream into 32-bit words with
// sop/eop/status, handling slave overflow, truncation and flush requests.
module gem_rx_writer
  import gem_rx_pkg::*;
#(
  parameter int MAX_FRAME_BYTES = 16383,
  parameter int LEN_W           = 14
) (
  input  logic                rx_clock,
  input  logic                rx_reset,
  input  logic [7:0]          s_tdata,
  input  logic                s_tvalid,
  output logic                s_tready,
  input  logic                s_tlast,
  input  logic                s_tuser,
  input  logic                flush_req,
  output logic                rx_w_wr,
  output logic [31:0]         rx_w_data,
  output logic                rx_w_sop,
  output logic                rx_w_eop,
  output logic [STATUS_W-1:0] rx_w_status,
  output logic                rx_w_err,
  input  logic                rx_w_overflow,
  output logic                rx_w_flush,
  output logic [31:0]         frame_count,
  output logic [31:0]         overflow_count
);

  function automatic logic [STATUS_W-1:0] build_status(
    input logic [LEN_W-1:0] len, input logic in_err, input logic ovf, input logic trunc);
    logic [STATUS_W-1:0] s;
    s = '0;
    s[STATUS_LEN_LSB +: LEN_W] = len;
    s[STATUS_ERR_BIT]          = in_err;
    s[STATUS_OVF_BIT]          = ovf;
    s[STATUS_TRUNC_BIT]        = trunc;
    return s;
  endfunction

  rx_ctl_t             ctl_q, ctl_d;
  rx_state_e           state_d;
  logic                pend_d, sop_done_d, ready_q, ready_d;
  logic                accept, flush_serve, frame_open, trunc, byte_keep;
  logic                is_last, ovf_abort, eop_now, wr_now;
  logic [LEN_W-1:0]    byte_cnt_q, byte_cnt_d, len_now;
  logic [31:0]         word;
  logic                word_full;
  logic                wr_d, sop_d, eop_d, err_d, flush_d;
  logic [31:0]         data_d;
  logic [STATUS_W-1:0] status_d;

  // Handshake: a byte transfers on any cycle where s_tvalid and s_tready are both
  // high. s_tready is registered, except that a flush being served from IDLE
  // withdraws it in the same cycle so no byte slips in ahead of the flush.
  assign flush_serve = (ctl_q.state == IDLE) & (flush_req | ctl_q.flush_pend);
  assign s_tready    = ready_q & ~flush_serve;
  assign accept      = s_tvalid & s_tready;

  assign frame_open = (ctl_q.state == PACK) & ctl_q.sop_done;
  assign trunc      = (ctl_q.state == PACK) & accept & (byte_cnt_q == LEN_W'(MAX_FRAME_BYTES));
  assign byte_keep  = accept & ((ctl_q.state == IDLE) | (ctl_q.state == PACK)) & ~trunc;
  assign is_last    = byte_keep & s_tlast;
  assign ovf_abort  = frame_open & rx_w_overflow;
  assign eop_now    = is_last | trunc | ovf_abort;
  assign wr_now     = word_full | eop_now;
  assign len_now    = byte_cnt_q + LEN_W'(byte_keep);

  gem_rx_byte_packer u_packer (
    .rx_clock  (rx_clock),
    .rx_reset  (rx_reset),
    .byte_data (s_tdata),
    .byte_en   (byte_keep),
    .close     (eop_now),
    .word      (word),
    .word_full (word_full)
  );

  always_comb begin
    state_d = ctl_q.state;
    case (ctl_q.state)
      IDLE: begin
        if (flush_serve) state_d = FLUSH;
        else if (accept && !s_tlast) state_d = PACK;
      end
      PACK: begin
        if (trunc || ovf_abort) state_d = (accept && s_tlast) ? IDLE : DISCARD;
        else if (is_last) state_d = IDLE;
      end
      DISCARD: if (accept && s_tlast) state_d = IDLE;
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_d       = wr_now;
    data_d     = wr_now ? word : 32'd0;
    sop_d      = wr_now & ~ctl_q.sop_done;
    eop_d      = eop_now;
    status_d   = eop_now ? build_status(len_now, is_last & s_tuser, ovf_abort, trunc) : '0;
    err_d      = eop_now & ((is_last & s_tuser) | ovf_abort | trunc);
    flush_d    = flush_serve;
    byte_cnt_d = eop_now ? '0 : len_now;
    sop_done_d = eop_now ? 1'b0 : (ctl_q.sop_done | wr_now);
    // Requests arriving mid-frame wait for IDLE; repeats collapse into one.
    pend_d     = ((ctl_q.state == PACK) | (ctl_q.state == DISCARD)) &
                 (ctl_q.flush_pend | flush_req);
    ready_d    = (state_d != FLUSH) & ~((state_d == IDLE) & pend_d);
  end

  assign ctl_d = '{state: state_d, flush_pend: pend_d, sop_done: sop_done_d};

  always_ff @(posedge rx_clock or posedge rx_reset) begin
    if (rx_reset) begin
      ctl_q          <= '{state: IDLE, flush_pend: 1'b0, sop_done: 1'b0};
      ready_q        <= 1'b0;
      byte_cnt_q     <= '0;
      rx_w_wr        <= 1'b0;
      rx_w_data      <= '0;
      rx_w_sop       <= 1'b0;
      rx_w_eop       <= 1'b0;
      rx_w_status    <= '0;
      rx_w_err       <= 1'b0;
      rx_w_flush     <= 1'b0;
      frame_count    <= '0;
      overflow_count <= '0;
    end else begin
      ctl_q       <= ctl_d;
      ready_q     <= ready_d;
      byte_cnt_q  <= byte_cnt_d;
      rx_w_wr     <= wr_d;
      rx_w_data   <= data_d;
      rx_w_sop    <= sop_d;
      rx_w_eop    <= eop_d;
      rx_w_status <= status_d;
      rx_w_err    <= err_d;
      rx_w_flush  <= flush_d;
      if (eop_now)   frame_count    <= frame_count + 32'd1;
      if (ovf_abort) overflow_count <= overflow_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_gem_rx_writer.sv
// Directed bench for gem_rx_writer: every FIFO write is checked against an
// expected queue of {sop, eop, err, status, data} records built by hand.
module tb_gem_rx_writer;

  logic        rx_clock = 1'b0;
  logic        rx_reset = 1'b1;
  logic [7:0]  s_tdata = 8'd0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast = 1'b0;
  logic        s_tuser = 1'b0;
  logic        flush_req = 1'b0;
  logic        rx_w_wr;
  logic [31:0] rx_w_data;
  logic        rx_w_sop;
  logic        rx_w_eop;
  logic [44:0] rx_w_status;
  logic        rx_w_err;
  logic        rx_w_overflow = 1'b0;
  logic        rx_w_flush;
  logic [31:0] frame_count;
  logic [31:0] overflow_count;

  gem_rx_writer dut (
    .rx_clock       (rx_clock),
    .rx_reset       (rx_reset),
    .s_tdata        (s_tdata),
    .s_tvalid       (s_tvalid),
    .s_tready       (s_tready),
    .s_tlast        (s_tlast),
    .s_tuser        (s_tuser),
    .flush_req      (flush_req),
    .rx_w_wr        (rx_w_wr),
    .rx_w_data      (rx_w_data),
    .rx_w_sop       (rx_w_sop),
    .rx_w_eop       (rx_w_eop),
    .rx_w_status    (rx_w_status),
    .rx_w_err       (rx_w_err),
    .rx_w_overflow  (rx_w_overflow),
    .rx_w_flush     (rx_w_flush),
    .frame_count    (frame_count),
    .overflow_count (overflow_count)
  );

  // ---------------- clock / reset ----------------
  always #5 rx_clock = ~rx_clock;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int          total = 0;
  int          bad = 0;
  int          flush_seen = 0;
  string       phase = "reset";
  logic [79:0] exp_q[$];

  function automatic logic [79:0] rec(input logic sop, input logic eop, input logic err,
                                      input logic [44:0] st, input logic [31:0] d);
    return {sop, eop, err, st, d};
  endfunction

  function automatic logic [44:0] stat(input int len, input logic e, input logic o, input logic t);
    logic [44:0] s;
    s = '0;
    s[13:0] = len[13:0];
    s[14] = e;
    s[15] = o;
    s[16] = t;
    return s;
  endfunction

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge rx_clock) begin
    if (rx_w_flush) flush_seen++;
    if (rx_w_wr) begin
      if (exp_q.size() == 0) begin
        total++;
        assert (exp_q.size() != 0) else begin
          bad++;
          $error("FAIL %s_wr_unexpected got=%0h exp=none", phase,
                 rec(rx_w_sop, rx_w_eop, rx_w_err, rx_w_status, rx_w_data));
        end
      end else begin
        check({phase, "_wr"}, rec(rx_w_sop, rx_w_eop, rx_w_err, rx_w_status, rx_w_data),
              exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] d, input logic last, input logic user);
    logic ok;
    s_tdata  = d;
    s_tvalid = 1'b1;
    s_tlast  = last;
    s_tuser  = user;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge rx_clock);
      ok = s_tready;
      @(posedge rx_clock);
      #1;
    end
    if (!ok) check({phase, "_tready_timeout"}, 80'(s_tready), 80'd1);
  endtask

  task automatic idle_bus();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
    s_tdata  = 8'd0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge rx_clock);
      #1;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int          fs0;
    logic [31:0] d;

    // reset state
    @(negedge rx_clock);
    @(negedge rx_clock);
    check("rst_tready", 80'(s_tready), '0);
    check("rst_flags", 80'({rx_w_wr, rx_w_sop, rx_w_eop, rx_w_err, rx_w_flush}), '0);
    check("rst_data", 80'(rx_w_data), '0);
    check("rst_status", 80'(rx_w_status), '0);
    check("rst_counts", 80'({frame_count, overflow_count}), '0);
    @(posedge rx_clock);
    #1 rx_reset = 1'b0;
    cycles(2);
    check("ready_after_reset", 80'(s_tready), 80'd1);

    // 6-byte frame
    phase = "t1";
    exp_q.push_back(rec(1'b1, 1'b0, 1'b0, '0, 32'h04030201));
    exp_q.push_back(rec(1'b0, 1'b1, 1'b0, stat(6, 1'b0, 1'b0, 1'b0), 32'h00000605));
    for (int i = 1; i <= 6; i++) send_byte(8'(i), i == 6, 1'b0);
    idle_bus();
    cycles(3);
    check("t1_drain", 80'(exp_q.size()), '0);
    check("t1_fc", 80'(frame_count), 80'd1);

    // 3-byte frame with input error
    phase = "t2";
    exp_q.push_back(rec(1'b1, 1'b1, 1'b1, stat(3, 1'b1, 1'b0, 1'b0), 32'h00CCBBAA));
    send_byte(8'hAA, 1'b0, 1'b0);
    send_byte(8'hBB, 1'b0, 1'b0);
    send_byte(8'hCC, 1'b1, 1'b1);
    idle_bus();
    cycles(3);
    check("t2_drain", 80'(exp_q.size()), '0);
    check("t2_fc", 80'(frame_count), 80'd2);

    // overflow while the 2nd word is on the bus; byte 8 is accepted that cycle
    phase = "t3";
    exp_q.push_back(rec(1'b1, 1'b0, 1'b0, '0, 32'h03020100));
    exp_q.push_back(rec(1'b0, 1'b0, 1'b0, '0, 32'h07060504));
    exp_q.push_back(rec(1'b0, 1'b1, 1'b1, stat(9, 1'b0, 1'b1, 1'b0), 32'h00000008));
    for (int i = 0; i < 64; i++) begin
      if (i == 8) rx_w_overflow = 1'b1;
      send_byte(8'(i), i == 63, 1'b0);
      if (i == 8) rx_w_overflow = 1'b0;
    end
    idle_bus();
    cycles(3);
    check("t3_drain", 80'(exp_q.size()), '0);
    check("t3_oc", 80'(overflow_count), 80'd1);
    check("t3_fc", 80'(frame_count), 80'd3);

    // two flush requests mid-frame collapse into one flush after the frame
    phase = "t4";
    fs0 = flush_seen;
    exp_q.push_back(rec(1'b1, 1'b0, 1'b0, '0, 32'h13121110));
    exp_q.push_back(rec(1'b0, 1'b1, 1'b0, stat(8, 1'b0, 1'b0, 1'b0), 32'h17161514));
    for (int i = 0; i < 8; i++) begin
      flush_req = (i == 3) || (i == 6);
      send_byte(8'(8'h10 + i), i == 7, 1'b0);
    end
    flush_req = 1'b0;
    idle_bus();
    @(negedge rx_clock);
    check("t4_hold_ready", 80'(s_tready), '0);
    @(negedge rx_clock);
    check("t4_flush_cycle", 80'({rx_w_flush, s_tready}), 80'b10);
    cycles(3);
    check("t4_one_flush", 80'(flush_seen - fs0), 80'd1);
    check("t4_drain", 80'(exp_q.size()), '0);
    check("t4_fc", 80'(frame_count), 80'd4);
    check("t4_ready_back", 80'(s_tready), 80'd1);

    // flush request in IDLE blocks a byte offered in the same cycle
    phase = "t4b";
    fs0 = flush_seen;
    flush_req = 1'b1;
    s_tvalid  = 1'b1;
    s_tdata   = 8'h55;
    s_tlast   = 1'b1;
    @(negedge rx_clock);
    check("t4b_no_accept", 80'(s_tready), '0);
    @(posedge rx_clock);
    #1;
    flush_req = 1'b0;
    idle_bus();
    cycles(3);
    check("t4b_one_flush", 80'(flush_seen - fs0), 80'd1);
    check("t4b_fc", 80'(frame_count), 80'd4);

    // oversize frame: 16390 bytes, truncated at 16383, then a normal 4-byte frame
    phase = "t5";
    for (int j = 0; j < 4095; j++) begin
      d = {8'(4 * j + 3), 8'(4 * j + 2), 8'(4 * j + 1), 8'(4 * j)};
      exp_q.push_back(rec(j == 0, 1'b0, 1'b0, '0, d));
    end
    exp_q.push_back(rec(1'b0, 1'b1, 1'b1, stat(16383, 1'b0, 1'b0, 1'b1), 32'h00FEFDFC));
    exp_q.push_back(rec(1'b1, 1'b1, 1'b0, stat(4, 1'b0, 1'b0, 1'b0), 32'hA4A3A2A1));
    for (int k = 0; k < 16390; k++) send_byte(8'(k), k == 16389, 1'b0);
    for (int k = 1; k <= 4; k++) send_byte(8'(8'hA0 + k), k == 4, 1'b0);
    idle_bus();
    cycles(3);
    check("t5_drain", 80'(exp_q.size()), '0);
    check("t5_fc", 80'(frame_count), 80'd6);
    check("t5_oc", 80'(overflow_count), 80'd1);

    // reset after 5 bytes: outputs clear at once, no eop, next frame has sop
    phase = "t6";
    exp_q.push_back(rec(1'b1, 1'b0, 1'b0, '0, 32'h24232221));
    for (int k = 1; k <= 5; k++) send_byte(8'(8'h20 + k), 1'b0, 1'b0);
    rx_reset = 1'b1;
    idle_bus();
    #1;
    check("t6_flags", 80'({rx_w_wr, rx_w_sop, rx_w_eop, rx_w_err, rx_w_flush, s_tready}), '0);
    check("t6_data_status", 80'({rx_w_data, rx_w_status}), '0);
    check("t6_counts", 80'({frame_count, overflow_count}), '0);
    @(posedge rx_clock);
    #1 rx_reset = 1'b0;
    cycles(2);
    exp_q.push_back(rec(1'b1, 1'b1, 1'b0, stat(2, 1'b0, 1'b0, 1'b0), 32'h00003231));
    send_byte(8'h31, 1'b0, 1'b0);
    send_byte(8'h32, 1'b1, 1'b0);
    idle_bus();
    cycles(3);
    check("t6_drain", 80'(exp_q.size()), '0);
    check("t6_fc", 80'(frame_count), 80'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
